serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor with a start/done handshake.
- Successor to the combinational 8-bit ripple add/sub: width is generic, and the datapath processes DIGIT bits per clock.
- Adds a full flag set (carry, overflow, zero, negative), operand capture and result hold.
- Sits between the register file and the accumulator in the mini CPU datapath, where area matters more than single-cycle latency.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥2.
- DIGIT, 1, bits processed per clock; WIDTH must be an integer multiple of DIGIT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while busy=0
- op  input  1  0 = a+b, 1 = a−b; captured with start
- a  input  WIDTH  operand A; captured with start
- b  input  WIDTH  operand B; captured with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result and flags valid/updated
- sum  output  WIDTH  result; held until the next completion
- carry  output  1  carry out of MSB (for subtract, 1 = no borrow)
- overflow  output  1  signed overflow
- zero  output  1  sum == 0
- negative  output  1  sum[WIDTH-1]

Behaviour:
- N = WIDTH/DIGIT compute cycles.
- Reset (async assert, sync release): state IDLE; busy, done, sum, carry, overflow, zero, negative all 0; internal shift registers, carry and counter cleared.
- Reset mid-operation aborts it. No done is issued and the previous result is lost (outputs go to 0).
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter 0..N-1.
  - DONE: busy=0, done=1, lasts one cycle.
- IDLE/DONE with start=1 at edge E0:
  - Capture a, op.
  - Capture b XOR {WIDTH{op}}.
  - Internal carry := op.
  - Counter := 0; go to RUN.
- IDLE/DONE with start=0: go to / stay in IDLE.
- RUN, each edge:
  - Add the low DIGIT bits of both operand registers plus the internal carry.
  - Shift the digit result into the result register from the MSB side.
  - Shift the operands right by DIGIT.
  - Update the internal carry; increment the counter.
- On the edge ending counter N-1:
  - Register the outputs: sum := result; carry := final carry.
  - overflow := carry into MSB XOR carry out of MSB, equivalently (sign A == sign B' ) AND (sign sum ≠ sign A), where B' is the possibly-inverted B.
  - zero := (sum==0); negative := sum MSB.
  - Go to DONE.
- Timing: start sampled at E0 → busy high from after E0 through edge E0+N → done high for exactly the one cycle following edge E0+N. Latency = N cycles; back-to-back throughput = one operation per N+1 cycles.
- start while busy=1 is ignored: no queueing, no effect on the current operation.
- start held high continuously gives back-to-back operations. Each DONE cycle re-samples start; done still pulses once per operation.
- a, b and op may change freely after the capture edge without affecting the result.
- sum and flags change only on completion (or reset). They hold their values during RUN and IDLE.
- Arithmetic is modulo 2^WIDTH. The carry/overflow semantics are identical to a WIDTH-bit ripple add/sub with carry-in = op.

Test Plan:
- WIDTH=8, DIGIT=1:
  - a=0x01, b=0x01, op=0, start pulse → busy for 8 cycles; done in cycle 9 after the start edge; sum=0x02, carry=0, overflow=0, zero=0, negative=0.
  - a=0x01, b=0x01, op=1 → sum=0x00, zero=1, carry=1 (no borrow), overflow=0.
  - a=0x7F, b=0x01, op=0 → sum=0x80, overflow=1, negative=1, carry=0. Then a=0x80, b=0x01, op=1 → sum=0x7F, overflow=1, carry=1, negative=0.
  - a=0xFF, b=0xFF, op=0 → sum=0xFE, carry=1, overflow=0, negative=1. In the same run, change a/b/op at cycle 3 and pulse start at cycle 4 → result unchanged, only one done, second start ignored.
- WIDTH=16, DIGIT=4: a=0x7FFF, b=0x8000, op=1 → done exactly 4 cycles after the start edge; sum=0xFFFF, overflow=1, carry=0. Hold start high → second done 5 cycles after the first.
- Reset mid-op: start a=0x10, b=0x20, then assert rst_n=0 asynchronously at RUN cycle 3 → busy, done and all outputs go to 0 immediately; after release, no done is seen until a new start.

Source files
------------

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, start/done handshake,
// result and flags (carry, overflow, zero, negative) held until the next completion.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIGIT:0]     w_dsum;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_last;
    logic               w_take;
    logic               w_ovf;

    assign w_dsum     = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
    assign w_res_next = WIDTH'({w_dsum[DIGIT-1:0], r_res} >> DIGIT);
    assign w_last     = (r_cnt == CNT_W'(N - 1));
    assign w_take     = start && (r_state != S_RUN);
    // On the last digit the operand registers hold the top digit, so their bit DIGIT-1 is the sign.
    assign w_ovf      = (r_a[DIGIT-1] == r_b[DIGIT-1]) && (w_res_next[WIDTH-1] != r_a[DIGIT-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (w_take) begin
            r_a   <= a;
            r_b   <= b ^ {WIDTH{op}};
            r_c   <= op;
            r_res <= '0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= r_a >> DIGIT;
            r_b   <= r_b >> DIGIT;
            r_res <= w_res_next;
            r_c   <= w_dsum[DIGIT];
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                sum      <= w_res_next;
                carry    <= w_dsum[DIGIT];
                overflow <= w_ovf;
                zero     <= (w_res_next == '0);
                negative <= w_res_next[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: an 8-bit/1-bit-digit instance and a 16-bit/4-bit-digit instance,
// expected results queued at start and compared at done.
module tb_serial_addsub;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start8, op8, busy8, done8, c8, v8, z8, n8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, op16, busy16, done16, c16, v16, z16, n16;
    logic [15:0] a16, b16, sum16;

    int   tests;
    int   fails;
    exp_t q8[$];
    exp_t q16[$];

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(c8), .overflow(v8),
        .zero(z8), .negative(n8)
    );

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .carry(c16), .overflow(v16),
        .zero(z16), .negative(n16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic op);
        exp_t        e;
        logic [15:0] mask;
        logic [15:0] bb;
        logic [16:0] full;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        bb   = (op ? ~b : b) & mask;
        full = {1'b0, a & mask} + {1'b0, bb} + {16'd0, op};
        e.s  = full[15:0] & mask;
        e.c  = full[w];
        e.n  = e.s[w-1];
        e.v  = (a[w-1] == bb[w-1]) && (e.n != a[w-1]);
        e.z  = (e.s == 16'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit sel16, input int budget, output int k, output bit got,
                             output int busycnt);
        got = 1'b0;
        k = 0;
        busycnt = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (sel16 ? done16 : done8) begin
                got = 1'b1;
                k = i;
                break;
            end
            if (sel16 ? busy16 : busy8) busycnt++;
        end
    endtask

    task automatic compare8(input string tag);
        exp_t e;
        check({tag, "_sb"}, 32'(q8.size() > 0), 32'd1);
        if (q8.size() > 0) begin
            e = q8.pop_front();
            check({tag, "_sum"}, 32'(sum8), 32'(e.s[7:0]));
            check({tag, "_c"}, 32'(c8), 32'(e.c));
            check({tag, "_v"}, 32'(v8), 32'(e.v));
            check({tag, "_z"}, 32'(z8), 32'(e.z));
            check({tag, "_n"}, 32'(n8), 32'(e.n));
        end
    endtask

    task automatic compare16(input string tag);
        exp_t e;
        check({tag, "_sb"}, 32'(q16.size() > 0), 32'd1);
        if (q16.size() > 0) begin
            e = q16.pop_front();
            check({tag, "_sum"}, 32'(sum16), 32'(e.s));
            check({tag, "_c"}, 32'(c16), 32'(e.c));
            check({tag, "_v"}, 32'(v16), 32'(e.v));
            check({tag, "_z"}, 32'(z16), 32'(e.z));
            check({tag, "_n"}, 32'(n16), 32'(e.n));
        end
    endtask

    // Start one 8-bit operation, verify busy/hold/latency, then score the result.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic op);
        logic [7:0] prev;
        int         k;
        bit         got;
        int         bc;
        @(negedge clk);
        prev   = sum8;
        a8     = a;
        b8     = b;
        op8    = op;
        start8 = 1'b1;
        q8.push_back(model(8, {8'd0, a}, {8'd0, b}, op));
        @(negedge clk);
        start8 = 1'b0;
        check({tag, "_busy0"}, 32'(busy8), 32'd1);
        check({tag, "_hold"}, 32'(sum8), 32'(prev));
        wait_done(1'b0, 20, k, got, bc);
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_lat"}, 32'(k), 32'd8);
        check({tag, "_busycyc"}, 32'(bc), 32'd7);
        if (got) compare8(tag);
    endtask

    initial begin
        int  k1;
        int  k2;
        bit  got;
        int  bc;
        int  dcnt;
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        start8  = 1'b0;
        op8     = 1'b0;
        a8      = '0;
        b8      = '0;
        start16 = 1'b0;
        op16    = 1'b0;
        a16     = '0;
        b16     = '0;

        repeat (2) @(negedge clk);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_out8", 32'({sum8, c8, v8, z8, n8}), 32'd0);
        check("rst_out16", 32'({busy16, done16, sum16, c16, v16, z16, n16}), 32'd0);
        rst_n = 1'b1;

        run8("add_1_1", 8'h01, 8'h01, 1'b0);
        run8("sub_1_1", 8'h01, 8'h01, 1'b1);
        run8("add_7f_1", 8'h7F, 8'h01, 1'b0);
        run8("sub_80_1", 8'h80, 8'h01, 1'b1);

        // FF+FF with inputs disturbed at cycle 3 and a stray start while busy at cycle 4.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; op8 = 1'b0; start8 = 1'b1;
        q8.push_back(model(8, 16'h00FF, 16'h00FF, 1'b0));
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; op8 = 1'b1;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(1'b0, 20, k1, got, bc);
        check("ff_done", 32'(got), 32'd1);
        check("ff_lat", 32'(k1 + 5), 32'd8);
        if (got) compare8("ff");
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) dcnt++;
        end
        check("ff_no_extra_done", 32'(dcnt), 32'd0);
        check("ff_idle", 32'(busy8), 32'd0);

        // 16-bit, 4-bit digits, start held high for two back-to-back operations.
        @(negedge clk);
        a16 = 16'h7FFF; b16 = 16'h8000; op16 = 1'b1; start16 = 1'b1;
        q16.push_back(model(16, 16'h7FFF, 16'h8000, 1'b1));
        q16.push_back(model(16, 16'h7FFF, 16'h8000, 1'b1));
        @(negedge clk);
        check("w16_busy0", 32'(busy16), 32'd1);
        wait_done(1'b1, 20, k1, got, bc);
        check("w16_done1", 32'(got), 32'd1);
        check("w16_lat", 32'(k1), 32'd4);
        if (got) compare16("w16_first");
        wait_done(1'b1, 20, k2, got, bc);
        start16 = 1'b0;
        check("w16_done2", 32'(got), 32'd1);
        check("w16_gap", 32'(k2), 32'd5);
        if (got) compare16("w16_second");
        @(negedge clk);
        check("w16_idle", 32'({busy16, done16}), 32'd0);

        // Asynchronous reset in RUN cycle 3 aborts the operation.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; op8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy8", 32'(busy8), 32'd0);
        check("arst_out8", 32'({done8, sum8, c8, v8, z8, n8}), 32'd0);
        check("arst_out16", 32'({sum16, c16, v16, z16, n16}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) dcnt++;
        end
        check("arst_quiet", 32'(dcnt), 32'd0);
        run8("after_rst", 8'h10, 8'h20, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
